bec_operand_loader: RTL and testbench

BEC_OPERAND_LOADER -- requirements
Module: bec_operand_loader

---
 rtl/bec_operand_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_bec_operand_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bec_operand_loader.sv
// Host-side operand/key loader for a binary Edwards curve core.
// Assembles NUM_OPS operands and one key from BUS_W-wide host words (LSW first),
// pushes each operand to the core with a load/trig handshake, streams the key
// MSB-first on ki while the core runs, and optionally reads the result back.
// Optional feature: define BEC_LOADER_READBACK_EN to include the READ state
// and the rd_* result path; otherwise rd_valid/rd_data are tied to 0.
// Ports:
//   wb_clk_i, wb_rst_ni             clock, async active-low reset
//   bus_valid/bus_ready/bus_data    host word input
//   abort                           return to IDLE, discard partial data
//   core_data/core_load/core_trig   operand push handshake, load_status = index
//   core_ena/next_key/ki            run control and serial key bit
//   core_done/core_result           completion and result from the core
//   rd_valid/rd_ready/rd_data       result readback words
//   busy                            FSM not IDLE
module bec_operand_loader #(
    parameter int unsigned DATA_W  = 163,
    parameter int unsigned BUS_W   = 32,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_ni,
    input  logic                               bus_valid,
    output logic                               bus_ready,
    input  logic [BUS_W-1:0]                   bus_data,
    input  logic                               abort,
    output logic [DATA_W-1:0]                  core_data,
    output logic                               core_load,
    input  logic                               core_trig,
    output logic [$clog2(NUM_OPS+1)-1:0]       load_status,
    output logic                               core_ena,
    input  logic                               next_key,
    output logic                               ki,
    input  logic                               core_done,
    input  logic [DATA_W-1:0]                  core_result,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [BUS_W-1:0]                   rd_data,
    output logic                               busy
);
    localparam int unsigned WORDS = (DATA_W + BUS_W - 1) / BUS_W;
    localparam int unsigned PW    = WORDS * BUS_W;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LS_W  = $clog2(NUM_OPS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PUSH, KEY, RUN, READ} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LS_W-1:0]   ops_q, ops_d;
    logic [PW-1:0]     asm_q, asm_d, asm_shift;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              core_load_q, core_load_d;
    logic              core_ena_q, core_ena_d;
    logic              bus_ready_q, bus_ready_d;
    logic              busy_q, busy_d;
    logic              accept, word_last;
`ifdef BEC_LOADER_READBACK_EN
    logic [PW-1:0]     res_q, res_d;
    logic              rd_valid_q, rd_valid_d;
`else
    logic              unused_readback;
    assign unused_readback = ^{core_result, rd_ready};
`endif

    // New word enters at the top; after WORDS words word 0 sits at the bottom.
    assign asm_shift = (asm_q >> BUS_W) | (PW'(bus_data) << ((WORDS - 1) * BUS_W));
    assign accept    = bus_valid & bus_ready_q;
    assign word_last = (cnt_q == CNT_W'(WORDS - 1));

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ops_d       = ops_q;
        asm_d       = asm_q;
        op_d        = op_q;
        key_d       = key_q;
        core_load_d = core_load_q;
        core_ena_d  = core_ena_q;
`ifdef BEC_LOADER_READBACK_EN
        res_d       = res_q;
        rd_valid_d  = rd_valid_q;
`endif
        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    asm_d = asm_shift;
                    if (word_last) begin
                        cnt_d       = '0;
                        op_d        = asm_shift[DATA_W-1:0];
                        core_load_d = 1'b1;
                        state_d     = PUSH;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            PUSH: begin
                if (core_trig) begin
                    core_load_d = 1'b0;
                    ops_d       = ops_q + LS_W'(1);
                    state_d     = (ops_q == LS_W'(NUM_OPS - 1)) ? KEY : LOAD;
                end
            end
            KEY: begin
                if (accept) begin
                    asm_d = asm_shift;
                    if (word_last) begin
                        cnt_d      = '0;
                        key_d      = asm_shift[DATA_W-1:0];
                        core_ena_d = 1'b1;
                        state_d    = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (next_key) key_d = key_q << 1;
                if (core_done) begin
                    core_ena_d = 1'b0;
                    ops_d      = '0;
`ifdef BEC_LOADER_READBACK_EN
                    res_d      = PW'(core_result);
                    rd_valid_d = 1'b1;
                    state_d    = READ;
`else
                    state_d    = IDLE;
`endif
                end
            end
`ifdef BEC_LOADER_READBACK_EN
            READ: begin
                if (rd_ready) begin
                    res_d = res_q >> BUS_W;
                    if (word_last) begin
                        cnt_d      = '0;
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort overrides every other event this cycle.
        if (abort) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ops_d       = '0;
            asm_d       = '0;
            core_load_d = 1'b0;
            core_ena_d  = 1'b0;
`ifdef BEC_LOADER_READBACK_EN
            res_d       = '0;
            rd_valid_d  = 1'b0;
`endif
        end

        bus_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == KEY);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ops_q       <= '0;
            asm_q       <= '0;
            op_q        <= '0;
            key_q       <= '0;
            core_load_q <= 1'b0;
            core_ena_q  <= 1'b0;
            bus_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef BEC_LOADER_READBACK_EN
            res_q       <= '0;
            rd_valid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            asm_q       <= asm_d;
            op_q        <= op_d;
            key_q       <= key_d;
            core_load_q <= core_load_d;
            core_ena_q  <= core_ena_d;
            bus_ready_q <= bus_ready_d;
            busy_q      <= busy_d;
`ifdef BEC_LOADER_READBACK_EN
            res_q       <= res_d;
            rd_valid_q  <= rd_valid_d;
`endif
        end
    end

    assign bus_ready   = bus_ready_q;
    assign core_data   = op_q;
    assign core_load   = core_load_q;
    assign load_status = ops_q;
    assign core_ena    = core_ena_q;
    assign ki          = key_q[DATA_W-1];
    assign busy        = busy_q;
`ifdef BEC_LOADER_READBACK_EN
    assign rd_valid    = rd_valid_q;
    assign rd_data     = res_q[BUS_W-1:0];
`else
    assign rd_valid    = 1'b0;
    assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_bec_operand_loader.sv
// Directed bench for bec_operand_loader at DATA_W=163, BUS_W=32, NUM_OPS=4.
module tb_bec_operand_loader;
    localparam int unsigned DATA_W  = 163;
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned NUM_OPS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              bus_valid = 1'b0;
    logic              bus_ready;
    logic [BUS_W-1:0]  bus_data = '0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] core_data;
    logic              core_load;
    logic              core_trig = 1'b0;
    logic [2:0]        load_status;
    logic              core_ena;
    logic              next_key = 1'b0;
    logic              ki;
    logic              core_done = 1'b0;
    logic [DATA_W-1:0] core_result = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [BUS_W-1:0]  rd_data;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] OP1  = 163'h6_55555555_44444444_33333333_22222222_11111111;
    localparam logic [DATA_W-1:0] OPA  = 163'h7_12345678_12345678_12345678_12345678_12345678;
    localparam logic [DATA_W-1:0] OPR  = 163'h1_0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;

    bec_operand_loader #(.DATA_W(DATA_W), .BUS_W(BUS_W), .NUM_OPS(NUM_OPS)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data), .abort(abort),
        .core_data(core_data), .core_load(core_load), .core_trig(core_trig),
        .load_status(load_status), .core_ena(core_ena), .next_key(next_key), .ki(ki),
        .core_done(core_done), .core_result(core_result),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [BUS_W-1:0] w);
        bus_valid = 1'b1;
        bus_data  = w;
        step();
        bus_valid = 1'b0;
    endtask

    task automatic send6(input logic [BUS_W-1:0] lo, input logic [BUS_W-1:0] top);
        for (int i = 0; i < 5; i++) send_word(lo);
        send_word(top);
    endtask

    task automatic push_ack();
        core_trig = 1'b1;
        step();
        core_trig = 1'b0;
    endtask

    initial begin
        logic stable;
        logic [DATA_W-1:0] held;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_core_load", core_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_status", load_status, 0);
        chk("rst_core_ena", core_ena, 0);
        chk("rst_ki", ki, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_core_data", core_data, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Operand 0: all-ones words, top bits of word 5 dropped
        send6(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("op0_data", core_data, ONES);
        chk("op0_load", core_load, 1);
        chk("op0_status", load_status, 0);
        chk("op0_bus_ready", bus_ready, 0);
        chk("op0_busy", busy, 1);

        // core_trig low for 10 cycles: load/data must hold
        stable = 1'b1;
        held = core_data;
        for (int i = 0; i < 10; i++) begin
            step();
            if (core_load !== 1'b1 || core_data !== held) stable = 1'b0;
        end
        chk("op0_hold_stable", stable, 1);
        push_ack();
        chk("op0_ack_load", core_load, 0);
        chk("op0_ack_status", load_status, 1);
        chk("op0_ack_bus_ready", bus_ready, 1);

        // Operand 1: distinct words, LSW first
        send_word(32'h1111_1111); send_word(32'h2222_2222); send_word(32'h3333_3333);
        send_word(32'h4444_4444); send_word(32'h5555_5555); send_word(32'h6666_6666);
        chk("op1_data", core_data, OP1);
        chk("op1_status", load_status, 1);
        push_ack();

        // Operand 2, with a stray core_trig while loading
        core_trig = 1'b1;
        send_word(32'h0);
        core_trig = 1'b0;
        chk("stray_trig_status", load_status, 2);
        chk("stray_trig_ready", bus_ready, 1);
        for (int i = 0; i < 5; i++) send_word(32'h0);
        chk("op2_status", load_status, 2);
        push_ack();
        send6(32'h0, 32'h0);
        chk("op3_status", load_status, 3);
        push_ack();
        chk("key_state_status", load_status, 4);
        chk("key_state_ready", bus_ready, 1);
        chk("key_state_busy", busy, 1);

        // Key: only bit 162 set; bits above 162 in word 5 ignored
        send6(32'h0, 32'hFFFF_FFFC);
        chk("run_ena", core_ena, 1);
        chk("run_ki_msb", ki, 1);
        chk("run_bus_ready", bus_ready, 0);
        core_trig = 1'b1;
        step();
        core_trig = 1'b0;
        chk("run_trig_ignored", core_load, 0);
        chk("run_trig_ki", ki, 1);
        next_key = 1'b1;
        step();
        next_key = 1'b0;
        chk("ki_after_one", ki, 0);
        stable = 1'b1;
        next_key = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (ki !== 1'b0) stable = 1'b0;
        end
        next_key = 1'b0;
        chk("ki_after_200", stable, 1);
        chk("run_ena_held", core_ena, 1);

        // Completion
        core_result = DATA_W'(32'h5A);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("done_ena", core_ena, 0);
`ifdef BEC_LOADER_READBACK_EN
        chk("rd_valid0", rd_valid, 1);
        chk("rd_busy", busy, 1);
        rd_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rd_valid !== 1'b1 || rd_data !== 32'h5A) stable = 1'b0;
        end
        chk("rd_stall", stable, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rd_word%0d", i), rd_data, (i == 0) ? 32'h5A : 32'h0);
            step();
        end
        rd_ready = 1'b0;
        chk("rd_end_valid", rd_valid, 0);
`else
        chk("nord_valid", rd_valid, 0);
        chk("nord_data", rd_data, 0);
`endif
        chk("done_idle_busy", busy, 0);
        chk("done_idle_ready", bus_ready, 1);
        chk("done_idle_status", load_status, 0);

        // Abort on the third operand word
        send_word(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        abort = 1'b1;
        send_word(32'hDEAD_BEEF);
        abort = 1'b0;
        chk("abort_load_busy", busy, 0);
        chk("abort_load_ready", bus_ready, 1);
        chk("abort_load_ena", core_ena, 0);
        send6(32'h1234_5678, 32'h7);
        chk("post_abort_data", core_data, OPA);
        chk("post_abort_status", load_status, 0);
        chk("post_abort_load", core_load, 1);

        // Walk to RUN, then abort together with core_done
        push_ack();
        for (int i = 0; i < 3; i++) begin
            send6(32'h0, 32'h0);
            push_ack();
        end
        send6(32'h0, 32'h4);
        chk("run2_ena", core_ena, 1);
        abort = 1'b1;
        core_done = 1'b1;
        step();
        abort = 1'b0;
        core_done = 1'b0;
        chk("abort_run_ena", core_ena, 0);
        chk("abort_run_busy", busy, 0);
        chk("abort_run_rd_valid", rd_valid, 0);
        chk("abort_run_status", load_status, 0);

        // Reset while in PUSH
        send6(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pre_rst_load", core_load, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_load", core_load, 0);
        chk("async_rst_ready", bus_ready, 1);
        chk("async_rst_status", load_status, 0);
        chk("async_rst_busy", busy, 0);
        #3 rst_n = 1'b1;
        step();
        send6(32'h0F0F_0F0F, 32'h1);
        chk("post_rst_data", core_data, OPR);
        chk("post_rst_status", load_status, 0);
        chk("post_rst_load", core_load, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
